// File: rtl/twos_pkg.sv
// ---------------------------------------------------------------------------
// twos_pkg
// Shared definitions for the bit-serial two's-complement conversion unit:
// conversion mode encodings and FSM state encodings.
// ---------------------------------------------------------------------------
package twos_pkg;

  // Conversion modes, as presented on in_mode.
  typedef enum logic [1:0] {
    MODE_NEG   = 2'b00,  // two's-complement negate
    MODE_ABS   = 2'b01,  // absolute value
    MODE_SM2TC = 2'b10,  // sign-magnitude -> two's complement
    MODE_TC2SM = 2'b11   // two's complement -> sign-magnitude
  } mode_t;

  // Control FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/twos_serial_bit.sv
// ---------------------------------------------------------------------------
// twos_serial_bit
// One-bit cell of the serial negator: copy bits up to and including the
// first one, invert every bit after it (when inversion is enabled).
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   d        in   current operand bit (LSB first); must be 0 when idle
//   inv_en   in   1 = apply the copy-then-invert rule, 0 = pass d through
//   clr      in   synchronous clear of seen_one (start of a new operand)
//   r        out  result bit for the current d
//   seen_one out  registered: a one has been seen in earlier bits
// ---------------------------------------------------------------------------
module twos_serial_bit (
  input  logic clk,
  input  logic rst,
  input  logic d,
  input  logic inv_en,
  input  logic clr,
  output logic r,
  output logic seen_one
);

  logic r_seen_one;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seen_one <= 1'b0;
    end else if (clr) begin
      r_seen_one <= 1'b0;
    end else if (d) begin
      r_seen_one <= 1'b1;
    end
  end

  assign r        = inv_en ? (d ^ r_seen_one) : d;
  assign seen_one = r_seen_one;

endmodule

// File: rtl/twos_serial_conv.sv
// ---------------------------------------------------------------------------
// twos_serial_conv
// Bit-serial two's-complement conversion unit. One operand bit per clock,
// LSB first; modes NEG, ABS, SM2TC and TC2SM. Valid/ready on both sides.
// Latency: out_valid rises WIDTH clocks after the accept edge; with
// out_ready tied high a new operand is accepted every WIDTH+2 clocks.
//
// Optional build macro:
//   TWOS_SAT_EN  when defined, overflowing results saturate
//                (NEG/ABS -> +max, TC2SM -> all ones); out_ovf still set.
//
// Parameters:
//   WIDTH  operand/result width, 2..32
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   in_valid   in   operand/mode present
//   in_ready   out  unit can accept an operand (IDLE only)
//   in_data    in   operand [WIDTH-1:0]
//   in_mode    in   00 NEG, 01 ABS, 10 SM2TC, 11 TC2SM
//   out_valid  out  result held and valid
//   out_ready  in   consumer takes result
//   out_data   out  result [WIDTH-1:0]
//   out_ovf    out  result not representable
// ---------------------------------------------------------------------------
module twos_serial_conv
  import twos_pkg::*;
#(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic             w_accept;
  logic             w_run;
  logic             w_last;

  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_opnd;
  logic [WIDTH-1:0] r_res;
  mode_t            r_mode;
  logic             r_inv_en;
  logic             r_sign;
  logic             r_ovf;

  mode_t            w_in_mode;
  logic             w_d;
  logic             w_r;
  logic             w_seen_one;
  logic [WIDTH-1:0] w_fix;

  assign w_in_mode = mode_t'(in_mode);

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    w_accept  = 1'b0;
    w_run     = 1'b0;
    w_last    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept = 1'b1;
          w_next   = ST_RUN;
        end
      end
      ST_RUN: begin
        w_run = 1'b1;
        if (r_cnt == LAST_BIT) begin
          w_last = 1'b1;
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // ---------------- serial cell ----------------
  // d is forced to 0 outside RUN so seen_one only accumulates operand bits.
  assign w_d = w_run & r_opnd[0];

  twos_serial_bit u_bit (
    .clk      (clk),
    .rst      (rst),
    .d        (w_d),
    .inv_en   (r_inv_en),
    .clr      (w_accept),
    .r        (w_r),
    .seen_one (w_seen_one)
  );

  // ---------------- datapath ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_opnd   <= '0;
      r_res    <= '0;
      r_mode   <= MODE_NEG;
      r_inv_en <= 1'b0;
      r_sign   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_cnt    <= '0;
      // SM2TC negates the magnitude only, so its sign bit enters as 0.
      r_opnd   <= {in_data[WIDTH-1] & (w_in_mode != MODE_SM2TC), in_data[WIDTH-2:0]};
      r_res    <= '0;
      r_mode   <= w_in_mode;
      r_inv_en <= (w_in_mode == MODE_NEG) | in_data[WIDTH-1];
      r_sign   <= in_data[WIDTH-1];
      r_ovf    <= 1'b0;
    end else if (w_run) begin
      r_cnt  <= r_cnt + 1'b1;
      r_opnd <= {1'b0, r_opnd[WIDTH-1:1]};
      r_res  <= {w_r, r_res[WIDTH-1:1]};
      // Overflow is exactly "MSB set with no one below it"; the SM2TC sign
      // bit was cleared on entry, so that mode can never flag here.
      if (w_last) begin
        r_ovf <= w_d & ~w_seen_one;
      end
    end
  end

  // ---------------- result fixups ----------------
  // SM2TC with a positive operand runs with inversion off, so the operand
  // already passes through unchanged and needs no extra mux.
  always_comb begin
    w_fix = r_res;
    if ((r_mode == MODE_TC2SM) && r_sign) begin
      w_fix[WIDTH-1] = 1'b1;
    end
`ifdef TWOS_SAT_EN
    if (r_ovf) begin
      w_fix = (r_mode == MODE_TC2SM) ? '1 : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  assign out_data = w_fix;
  assign out_ovf  = r_ovf;

endmodule

// File: tb/tb_twos_serial_conv.sv
module tb_twos_serial_conv;

  localparam int W = 7;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [1:0]   in_mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_ovf;

  twos_serial_conv #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Behavioural reference: signed arithmetic on the operand value.
  // Returns {ovf, result}.
  function automatic logic [W:0] model(input logic [1:0] m, input logic [W-1:0] d);
    longint v, mag, r;
    logic [63:0] rr;
    logic ovf;
    v   = longint'(d);
    if (d[W-1]) v = v - (longint'(1) << W);
    mag = longint'(d) & ((longint'(1) << (W-1)) - 1);
    case (m)
      2'b00: r = -v;
      2'b01: r = (v < 0) ? -v : v;
      2'b10: r = d[W-1] ? -mag : longint'(d);
      default: r = (v < 0) ? ((longint'(1) << (W-1)) | ((-v) & ((longint'(1) << (W-1)) - 1)))
                           : longint'(d);
    endcase
    rr  = r;
    ovf = (longint'(d) == (longint'(1) << (W-1))) && (m != 2'b10);
`ifdef TWOS_SAT_EN
    if (ovf) rr = (m == 2'b11) ? ((64'd1 << W) - 1) : ((64'd1 << (W-1)) - 1);
`endif
    return {ovf, rr[W-1:0]};
  endfunction

  // ---------------- compare process ----------------
  logic [W:0]  q[$];
  bit          busy = 0;
  int unsigned cyc = 0;
  int unsigned acc_cyc = 0;
  int unsigned n_out = 0;

  always @(negedge clk) begin
    bit exp_v;
    cyc++;
    if (rst) begin
      q.delete();
      busy = 0;
    end else begin
      check("in_ready", in_ready, !busy);
      exp_v = busy && ((cyc - acc_cyc) >= W + 1);
      check("out_valid", out_valid, exp_v);
      if (out_valid && exp_v && q.size() > 0) begin
        check("out_data", out_data, q[0][W-1:0]);
        check("out_ovf", out_ovf, q[0][W]);
        if (out_ready) begin
          void'(q.pop_front());
          busy = 0;
          n_out++;
        end
      end
      if (in_valid && in_ready && !busy) begin
        q.push_back(model(in_mode, in_data));
        busy = 1;
        acc_cyc = cyc;
      end
    end
  end

  // ---------------- directed operation with literal expectations ----------------
  task automatic run_op(input string nm, input logic [1:0] m, input logic [W-1:0] d,
                        input logic [W-1:0] ed, input logic eo, input int hold);
    int unsigned n;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    check({nm, "_idle"}, in_ready, 1'b1);
    in_valid = 1'b1; in_data = d; in_mode = m; out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 30) begin @(posedge clk); #1; n++; end
    check({nm, "_latency"}, n, W);
    check({nm, "_data"}, out_data, ed);
    check({nm, "_ovf"}, out_ovf, eo);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        in_valid = 1'b1; in_data = W'($urandom); in_mode = 2'($urandom);
        @(posedge clk); #1;
        check({nm, "_hold_valid"}, out_valid, 1'b1);
        check({nm, "_hold_data"}, out_data, ed);
        check({nm, "_hold_ovf"}, out_ovf, eo);
        check({nm, "_hold_in_ready"}, in_ready, 1'b0);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      check({nm, "_release_in_ready"}, in_ready, 1'b1);
      check({nm, "_release_out_valid"}, out_valid, 1'b0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned n;
    logic [W-1:0] sat_neg;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = 2'b00; out_ready = 1'b1;
    #3;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_out_ovf", out_ovf, 1'b0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;

`ifdef TWOS_SAT_EN
    sat_neg = 7'b0111111;
`else
    sat_neg = 7'b1000000;
`endif
    run_op("neg5",      2'b00, 7'b0000101, 7'b1111011, 1'b0, 0);
    run_op("negmin",    2'b00, 7'b1000000, sat_neg,    1'b1, 0);
    run_op("abs_neg",   2'b01, 7'b1111011, 7'b0000101, 1'b0, 0);
    run_op("abs_pos",   2'b01, 7'b0010110, 7'b0010110, 1'b0, 0);
    run_op("sm2tc_neg", 2'b10, 7'b1000101, 7'b1111011, 1'b0, 0);
    run_op("sm2tc_nz",  2'b10, 7'b1000000, 7'b0000000, 1'b0, 0);
    run_op("tc2sm_bp",  2'b11, 7'b1111011, 7'b1000101, 1'b0, 5);
    run_op("tc2sm_0",   2'b11, 7'b0000000, 7'b0000000, 1'b0, 0);
    run_op("neg_0",     2'b00, 7'b0000000, 7'b0000000, 1'b0, 0);

    // Back-to-back throughput with in_valid held high.
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    in_valid = 1'b1; in_mode = 2'b00; in_data = 7'b0000101; out_ready = 1'b1;
    @(posedge clk); #1;
    in_data = 7'b0000011;
    n = 0;
    while (!in_ready && n < 30) begin @(posedge clk); #1; n++; end
    check("accept_spacing", n + 1, W + 2);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!in_ready && n < 30) begin @(posedge clk); #1; n++; end

    // Reset in the middle of RUN.
    in_valid = 1'b1; in_mode = 2'b00; in_data = 7'b0101010;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_in_ready", in_ready, 1'b1);
    check("abort_out_data", out_data, '0);
    check("abort_out_ovf", out_ovf, 1'b0);
    @(negedge clk);
    @(posedge clk); #1; rst = 1'b0;
    run_op("neg1_after_rst", 2'b00, 7'd1, 7'b1111111, 1'b0, 0);

    // Randomised traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      int unsigned sel;
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 2) != 0);
      in_mode   = 2'($urandom);
      sel       = $urandom_range(0, 7);
      case (sel)
        0: in_data = '0;
        1: in_data = {1'b1, {(W-1){1'b0}}};
        2: in_data = '1;
        3: in_data = {1'b0, {(W-1){1'b1}}};
        default: in_data = W'($urandom);
      endcase
      out_ready = ($urandom_range(0, 3) != 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    check("drain_idle", in_ready, 1'b1);
    check("drain_queue", q.size(), 0);
    check("outputs_seen", (n_out > 100), 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
